// File: rtl/nd_2to1.sv
//==============================================================================
// Module      : nd_2to1
// Description : Two-input to one-output message merger with round-robin
//               arbitration, a shared FIFO and 4-phase handshakes everywhere.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module nd_2to1 #(
    parameter int FSZ = 4,
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE
) (
    input  logic           gch_clk,
    input  logic           gch_reset,
    output logic           gch_ready,

    input  logic           rcv0_req,
    output logic           rcv0_ack,
    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,

    input  logic           rcv1_req,
    output logic           rcv1_ack,
    input  logic [ASZ-1:0] rcv1_src,
    input  logic [ASZ-1:0] rcv1_dst,
    input  logic [DSZ-1:0] rcv1_dat,
    input  logic [RSZ-1:0] rcv1_red,

    output logic           snd0_req,
    input  logic           snd0_ack,
    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red
);

    localparam int c_ptr_w = $clog2(FSZ);
    localparam int c_cnt_w = $clog2(FSZ) + 1;
    localparam int c_msg_w = 2 * ASZ + DSZ + RSZ;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(FSZ);

    logic [c_msg_w-1:0] r_mem [FSZ];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic               r_last;

    logic               w_pend0;
    logic               w_pend1;
    logic               w_space;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_wr;
    logic               w_pop;
    logic [c_msg_w-1:0] w_wdata;
    logic [c_msg_w-1:0] w_head;

    assign w_pend0 = rcv0_req & ~rcv0_ack;
    assign w_pend1 = rcv1_req & ~rcv1_ack;
    assign w_space = (r_count < c_full);

    // r_last = 1 means input 1 was granted last, so input 0 wins a tie
    assign w_gnt0  = gch_ready & w_space & w_pend0 & (~w_pend1 | r_last);
    assign w_gnt1  = gch_ready & w_space & w_pend1 & (~w_pend0 | ~r_last);
    assign w_wr    = w_gnt0 | w_gnt1;
    assign w_wdata = w_gnt0 ? {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red}
                            : {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red};

    // The wait for snd0_ack to return low is the output's busy phase:
    // with snd0_req already low, snd0_ack=1 alone keeps the port occupied.
    assign w_pop   = gch_ready & ~snd0_req & ~snd0_ack & (r_count != '0);
    assign w_head  = r_mem[r_head];

    always_ff @(posedge gch_clk) begin
        if (w_wr) begin
            r_mem[r_tail] <= w_wdata;
        end
    end

    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) begin
            gch_ready <= 1'b0;
            rcv0_ack  <= 1'b0;
            rcv1_ack  <= 1'b0;
            snd0_req  <= 1'b0;
            snd0_src  <= '0;
            snd0_dst  <= '0;
            snd0_dat  <= '0;
            snd0_red  <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_last    <= 1'b1;
        end else begin
            gch_ready <= 1'b1;

            if (rcv0_ack) begin
                if (!rcv0_req) rcv0_ack <= 1'b0;
            end else if (w_gnt0) begin
                rcv0_ack <= 1'b1;
            end

            if (rcv1_ack) begin
                if (!rcv1_req) rcv1_ack <= 1'b0;
            end else if (w_gnt1) begin
                rcv1_ack <= 1'b1;
            end

            if (w_gnt0) r_last <= 1'b0;
            else if (w_gnt1) r_last <= 1'b1;

            if (w_wr) r_tail <= r_tail + c_ptr_w'(1);

            if (snd0_req) begin
                if (snd0_ack) snd0_req <= 1'b0;
            end else if (w_pop) begin
                snd0_req <= 1'b1;
                {snd0_src, snd0_dst, snd0_dat, snd0_red} <= w_head;
                r_head <= r_head + c_ptr_w'(1);
            end

            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nd_2to1.sv
//==============================================================================
// Module      : tb_nd_2to1
// Description : Randomized scoreboard bench for nd_2to1 with a rule-level model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_nd_2to1;

    localparam int FSZ = 4;
    localparam int A   = 8;
    localparam int D   = 16;
    localparam int R   = 4;
    localparam int MW  = 2 * A + D + R;

    typedef logic [MW-1:0] msg_t;
    typedef struct {
        msg_t m;
        int   id;
    } item_t;

    logic         gch_clk = 1'b0;
    logic         gch_reset;
    logic         gch_ready;
    logic         rcv0_req, rcv0_ack, rcv1_req, rcv1_ack;
    logic [A-1:0] rcv0_src, rcv0_dst, rcv1_src, rcv1_dst;
    logic [D-1:0] rcv0_dat, rcv1_dat;
    logic [R-1:0] rcv0_red, rcv1_red;
    logic         snd0_req, snd0_ack;
    logic [A-1:0] snd0_src, snd0_dst;
    logic [D-1:0] snd0_dat;
    logic [R-1:0] snd0_red;

    nd_2to1 #(.FSZ(FSZ), .ASZ(A), .DSZ(D), .RSZ(R)) dut (
        .gch_clk  (gch_clk),
        .gch_reset(gch_reset),
        .gch_ready(gch_ready),
        .rcv0_req (rcv0_req),
        .rcv0_ack (rcv0_ack),
        .rcv0_src (rcv0_src),
        .rcv0_dst (rcv0_dst),
        .rcv0_dat (rcv0_dat),
        .rcv0_red (rcv0_red),
        .rcv1_req (rcv1_req),
        .rcv1_ack (rcv1_ack),
        .rcv1_src (rcv1_src),
        .rcv1_dst (rcv1_dst),
        .rcv1_dat (rcv1_dat),
        .rcv1_red (rcv1_red),
        .snd0_req (snd0_req),
        .snd0_ack (snd0_ack),
        .snd0_src (snd0_src),
        .snd0_dst (snd0_dst),
        .snd0_dat (snd0_dat),
        .snd0_red (snd0_red)
    );

    always #5 gch_clk = ~gch_clk;

    int    errors = 0;
    int    checks = 0;
    bit    cons_en = 1'b1;
    bit    cons_rand = 1'b0;

    item_t fifo_q[$];
    item_t exp_q[$];
    int    grant_log[$];
    int    deliver_log[$];

    bit    have_pred = 1'b0;
    bit    m_ready, m_ack0, m_ack1, m_sreq, m_last;
    bit    out_valid = 1'b0;
    bit    prev_sreq = 1'b0;
    msg_t  cur_out;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the handshake, arbitration and FIFO rules once
    // per cycle using the values the DUT will see at the next rising edge.
    always @(negedge gch_clk) begin
        bit p0, p1, space, g0, g1, load, n_sreq;
        item_t it;
        if (!gch_reset) begin
            chk("reset_ctl", {gch_ready, rcv0_ack, rcv1_ack, snd0_req}, 4'b0000);
            chk("reset_fields", {snd0_src, snd0_dst, snd0_dat, snd0_red}, '0);
            fifo_q.delete();
            exp_q.delete();
            m_last = 1'b1; m_ready = 1'b0; m_ack0 = 1'b0; m_ack1 = 1'b0; m_sreq = 1'b0;
            have_pred = 1'b1;
        end else begin
            if (have_pred) begin
                chk("ready", gch_ready, m_ready);
                chk("rcv0_ack", rcv0_ack, m_ack0);
                chk("rcv1_ack", rcv1_ack, m_ack1);
                chk("snd0_req", snd0_req, m_sreq);
            end
            p0    = rcv0_req && !m_ack0;
            p1    = rcv1_req && !m_ack1;
            space = fifo_q.size() < FSZ;
            g0    = m_ready && space && p0 && (!p1 || m_last);
            g1    = m_ready && space && p1 && (!p0 || !m_last);
            load  = m_ready && !m_sreq && !snd0_ack && fifo_q.size() > 0;
            n_sreq = m_sreq ? !snd0_ack : load;
            if (load) exp_q.push_back(fifo_q.pop_front());
            if (g0) begin
                it.m = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red}; it.id = 0;
                fifo_q.push_back(it); grant_log.push_back(0); m_last = 1'b0;
            end
            if (g1) begin
                it.m = {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red}; it.id = 1;
                fifo_q.push_back(it); grant_log.push_back(1); m_last = 1'b1;
            end
            m_ack0  = m_ack0 ? rcv0_req : g0;
            m_ack1  = m_ack1 ? rcv1_req : g1;
            m_sreq  = n_sreq;
            m_ready = 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on each new snd0 request.
    always @(negedge gch_clk) begin
        item_t it;
        if (!gch_reset) begin
            prev_sreq = 1'b0;
            out_valid = 1'b0;
        end else begin
            if (snd0_req && !prev_sreq) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1'b1, 1'b0);
                end else begin
                    it = exp_q.pop_front();
                    chk("out_msg", {snd0_src, snd0_dst, snd0_dat, snd0_red}, it.m);
                    deliver_log.push_back(it.id);
                end
                cur_out   = {snd0_src, snd0_dst, snd0_dat, snd0_red};
                out_valid = 1'b1;
            end else if ((snd0_req || snd0_ack) && out_valid) begin
                chk("out_stable", {snd0_src, snd0_dst, snd0_dat, snd0_red}, cur_out);
            end
            prev_sreq = snd0_req;
        end
    end

    initial begin
        snd0_ack = 1'b0;
        forever begin
            @(posedge gch_clk); #1;
            if (snd0_req && !snd0_ack && cons_en && (!cons_rand || $urandom_range(1, 0) == 1))
                snd0_ack = 1'b1;
            else if (!snd0_req && snd0_ack && (!cons_rand || $urandom_range(1, 0) == 1))
                snd0_ack = 1'b0;
        end
    end

    function automatic logic ackv(input int n);
        return (n == 0) ? rcv0_ack : rcv1_ack;
    endfunction

    function automatic msg_t rmsg();
        return {A'($urandom), A'($urandom), D'($urandom), R'($urandom)};
    endfunction

    task automatic wait_ack(input int n, input logic val);
        int t = 0;
        while (ackv(n) !== val && t < 300) begin
            @(posedge gch_clk); #1; t++;
        end
        chk(n == 0 ? "ack0_wait" : "ack1_wait", ackv(n), val);
    endtask

    task automatic send(input int n, input int dly, input msg_t m);
        @(posedge gch_clk); #1;
        repeat (dly) begin @(posedge gch_clk); #1; end
        if (n == 0) begin {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = m; rcv0_req = 1'b1; end
        else        begin {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red} = m; rcv1_req = 1'b1; end
        wait_ack(n, 1'b1);
        if (n == 0) rcv0_req = 1'b0; else rcv1_req = 1'b0;
        wait_ack(n, 1'b0);
    endtask

    task automatic drain();
        int t = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || snd0_req || snd0_ack) && t < 600) begin
            @(posedge gch_clk); #1; t++;
        end
        chk("drain_timeout", t < 600, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge gch_clk); #1;
        gch_reset = 1'b0;
        repeat (2) begin @(posedge gch_clk); #1; end
        gch_reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        gch_reset = 1'b0;
        rcv0_req = 1'b0; rcv1_req = 1'b0;
        {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = '0;
        {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red} = '0;
        repeat (3) @(posedge gch_clk);
        #1 gch_reset = 1'b1;
        @(posedge gch_clk); #1;
        chk("ready_after_reset", gch_ready, 1'b1);

        // single message, dst=5 dat=0xA
        grant_log.delete(); deliver_log.delete();
        send(0, 0, {8'h11, 8'd5, 16'h000A, 4'h3});
        drain();
        chk("single_grants", grant_log.size(), 1);
        chk("single_delivered", deliver_log.size(), 1);

        // simultaneous requests right after reset
        do_reset();
        grant_log.delete(); deliver_log.delete();
        fork
            send(0, 0, rmsg());
            send(1, 0, rmsg());
        join
        drain();
        chk("tie_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        chk("tie_second", grant_log.size() > 1 ? grant_log[1] : -1, 1);
        chk("tie_out_order", deliver_log.size() > 1 ? {deliver_log[0], deliver_log[1]} : -1, {32'd0, 32'd1});

        // fairness: two streams of 8, prompt consumer
        do_reset();
        grant_log.delete(); deliver_log.delete();
        fork
            for (int i = 0; i < 8; i++) send(0, 0, rmsg());
            for (int j = 0; j < 8; j++) send(1, 0, rmsg());
        join
        drain();
        chk("fair_count", deliver_log.size(), 16);
        bad = 0;
        for (int k = 0; k < deliver_log.size(); k++) if (deliver_log[k] != k % 2) bad++;
        chk("fair_alternation", bad, 0);

        // random traffic with a slow, random consumer
        cons_rand = 1'b1;
        deliver_log.delete();
        fork
            for (int i = 0; i < 20; i++) send(0, $urandom_range(3, 0), rmsg());
            for (int j = 0; j < 20; j++) send(1, $urandom_range(3, 0), rmsg());
        join
        drain();
        cons_rand = 1'b0;
        chk("random_count", deliver_log.size(), 40);

        // full FIFO with output stalled
        cons_en = 1'b0;
        grant_log.delete(); deliver_log.delete();
        fork
            for (int i = 0; i < 6; i++) send(0, 0, rmsg());
            begin
                repeat (30) @(posedge gch_clk);
                #1;
                chk("full_grants", grant_log.size(), 5);
                chk("full_blocked", {rcv0_req, rcv0_ack}, 2'b10);
                cons_en = 1'b1;
            end
        join
        drain();
        chk("full_grants_after", grant_log.size(), 6);
        chk("full_delivered", deliver_log.size(), 6);

        // reset with traffic buffered and output request raised
        cons_en = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 0, rmsg());
        @(posedge gch_clk); #1;
        chk("pre_reset_sreq", snd0_req, 1'b1);
        gch_reset = 1'b0;
        #1;
        chk("async_reset", {gch_ready, rcv0_ack, rcv1_ack, snd0_req}, 4'b0000);
        repeat (2) @(posedge gch_clk);
        #1 gch_reset = 1'b1;
        @(posedge gch_clk); #1;
        chk("ready_after_release", gch_ready, 1'b1);
        repeat (4) @(posedge gch_clk);
        #1;
        chk("idle_after_reset", snd0_req, 1'b0);
        cons_en = 1'b1;
        deliver_log.delete();
        send(1, 0, rmsg());
        drain();
        chk("post_reset_delivered", deliver_log.size(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nd_2to1.md
ND_2TO1 -- requirements
Module: nd_2to1

Interface
REQ-001 SHALL have parameter FSZ, default 4, meaning shared FIFO depth in messages (power of 2, >=2).
REQ-002 SHALL have parameter ASZ, default `NS_ADDRESS_SIZE, meaning src/dst field width.
REQ-003 SHALL have parameter DSZ, default `NS_DATA_SIZE, meaning data field width.
REQ-004 SHALL have parameter RSZ, default `NS_REDUN_SIZE, meaning redundancy field width.
REQ-005 SHALL have ports: gch_clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have: gch_reset  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have: gch_ready  out  1  block initialised and operational.
REQ-008 SHALL have: rcv0_req, rcv1_req  in  1 each  input-channel request.
REQ-009 SHALL have: rcv0_ack, rcv1_ack  out  1 each  input-channel acknowledge.
REQ-010 SHALL have: rcvN_src, rcvN_dst  in  ASZ each; rcvN_dat  in  DSZ; rcvN_red  in  RSZ  (N=0,1) input message.
REQ-011 SHALL have: snd0_req  out  1; snd0_ack  in  1; snd0_src, snd0_dst  out  ASZ; snd0_dat  out  DSZ; snd0_red  out  RSZ  output channel.

Function
REQ-012 SHALL use 4-phase handshake on every channel: req rise -> ack rise -> req fall -> ack fall; message fields valid while req high.
REQ-013 SHALL treat input N as pending when rcvN_req=1 and rcvN_ack=0.
REQ-014 SHALL write at most one message per cycle into the FIFO; write allowed only when count < FSZ (or count = FSZ with a read in the same cycle: not allowed, full blocks writes).
REQ-015 SHALL arbitrate round-robin: if both pending, grant the input not granted last; if one pending, grant it; last-grant register resets to 1 (so input 0 wins first tie).
REQ-016 SHALL, on grant at edge N, store {src,dst,dat,red} at FIFO tail and set rcvN_ack=1 after edge N (latency 1 cycle from pending to ack).
REQ-017 SHALL hold rcvN_ack=1 until rcvN_req observed 0, then clear ack next edge; no new grant to that input while its ack is 1.
REQ-018 SHALL drive output from a registered message: when output idle (snd0_req=0, snd0_ack=0, not busy) and FIFO non-empty, load head into output regs, pop FIFO, set snd0_req=1 at same edge.
REQ-019 SHALL clear snd0_req the edge after snd0_ack=1 seen, mark busy, and clear busy when snd0_ack=0 seen; next message may load that same edge.
REQ-020 SHALL keep snd0_* fields stable from req rise until ack fall.
REQ-021 SHALL allow simultaneous FIFO write and pop in one cycle; count unchanged.
REQ-022 SHALL wrap head/tail pointers modulo FSZ; count width clog2(FSZ)+1.
REQ-023 SHALL, when FIFO full, leave pending input(s) un-acked until space frees; no message dropped or duplicated.
REQ-024 SHALL preserve per-input order; inter-input order follows grant order.

Reset
REQ-025 SHALL, while gch_reset=0 (asynchronously), force gch_ready=0, rcv0_ack=0, rcv1_ack=0, snd0_req=0, busy=0, FIFO empty (pointers, count = 0), last-grant=1, snd0_* fields = 0.
REQ-026 SHALL set gch_ready=1 on the first gch_clk edge after gch_reset rises; no grants or output loads before gch_ready=1.
REQ-027 SHALL discard all buffered and in-flight messages on reset mid-transfer; a partner left with req high is treated as newly pending after reset.

Verification
REQ-028 Single msg: FSZ=4, rcv0 sends dst=5 dat=0xA -> rcv0_ack rises 1 cycle after req; snd0_req rises next cycle with dst=5 dat=0xA; snd0 handshake completes, FIFO empty.
REQ-029 Tie: rcv0 and rcv1 req same cycle after reset -> rcv0 acked first, rcv1 next grant; snd0 order rcv0 msg then rcv1 msg.
REQ-030 Fairness: both inputs stream 8 msgs each, snd0_ack prompt -> output alternates 0,1,0,1...; all 16 delivered in per-input order.
REQ-031 Full: FSZ=4, snd0_ack held 0 -> after 4 writes plus 1 in output regs, further rcv req stays un-acked; releasing snd0_ack drains and resumes acks, no loss.
REQ-032 Reset mid-op: assert gch_reset=0 with 3 msgs buffered and snd0_req=1 -> snd0_req, acks, gch_ready drop immediately; after release gch_ready=1 next edge, snd0_req stays 0 until new input.
